// File: rtl/tl_ram_responder.sv
// TileLink-UL style responder wrapping a word-addressed synchronous RAM.
// Single-beat and 4-beat Get/Put requests, one transaction in flight, source echoed on D.
module tl_ram_responder #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_a_ready,
    input  logic        io_a_valid,
    input  logic [2:0]  io_a_bits_opcode,
    input  logic [3:0]  io_a_bits_size,
    input  logic        io_a_bits_source,
    input  logic [31:0] io_a_bits_address,
    input  logic [3:0]  io_a_bits_mask,
    input  logic [31:0] io_a_bits_data,
    input  logic        io_d_ready,
    output logic        io_d_valid,
    output logic [2:0]  io_d_bits_opcode,
    output logic [3:0]  io_d_bits_size,
    output logic        io_d_bits_source,
    output logic        io_d_bits_denied,
    output logic [31:0] io_d_bits_data,
    output logic [1:0]  dbg_state
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Handshake: a beat transfers on a channel in any cycle where valid & ready are both high;
    // D fields depend only on registered state, so they are stable while valid & !ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        WACK  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [AW-3:0]   base_q, base_d;
    logic            source_q, source_d;
    logic [3:0]      size_q, size_d;
    logic            denied_q, denied_d;
    logic            burst_q, burst_d;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            a_fire, d_fire;
    logic            req_get, req_illegal, req_burst;
    logic [AW-1:0]   req_index;
    logic            rd_en, wr_en;
    logic [AW-1:0]   rd_idx, wr_idx;
    logic            unused_addr;

    assign unused_addr = ^{io_a_bits_address[31:AW+2], io_a_bits_address[1:0]};

    assign io_a_ready = !reset && (state_q == IDLE || state_q == WRITE);
    assign io_d_valid = (state_q == READ) || (state_q == WACK);
    assign a_fire     = io_a_valid && io_a_ready;
    assign d_fire     = io_d_valid && io_d_ready;
    assign dbg_state  = state_q;

    assign io_d_bits_opcode = (state_q == READ) ? 3'd1 : 3'd0;
    assign io_d_bits_size   = io_d_valid ? size_q : 4'd0;
    assign io_d_bits_source = io_d_valid && source_q;
    assign io_d_bits_denied = io_d_valid && denied_q;
    assign io_d_bits_data   = (state_q == READ && !denied_q) ? rdata_q : 32'd0;

    always_comb begin
        req_get     = (io_a_bits_opcode == 3'd4);
        req_illegal = !(io_a_bits_opcode == 3'd0 || io_a_bits_opcode == 3'd1 || req_get)
                      || (io_a_bits_size == 4'd3) || (io_a_bits_size > 4'd4);
        req_burst   = !req_illegal && (io_a_bits_size == 4'd4);
        req_index   = req_burst ? {io_a_bits_address[AW+1:4], 2'b00} : io_a_bits_address[AW+1:2];
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        source_d = source_q;
        size_d   = size_q;
        denied_d = denied_q;
        burst_d  = burst_q;
        rd_en    = 1'b0;
        rd_idx   = req_index;
        wr_en    = 1'b0;
        wr_idx   = req_index;
        case (state_q)
            IDLE: begin
                if (a_fire) begin
                    source_d = io_a_bits_source;
                    size_d   = io_a_bits_size;
                    denied_d = req_illegal;
                    burst_d  = req_burst;
                    base_d   = io_a_bits_address[AW+1:4];
                    beat_d   = 2'd0;
                    if (req_get) begin
                        rd_en   = 1'b1;
                        state_d = READ;
                    end else begin
                        // Illegal non-Get requests are acknowledged but never touch the RAM.
                        wr_en = !req_illegal;
                        if (req_burst) begin
                            beat_d  = 2'd1;
                            state_d = WRITE;
                        end else begin
                            state_d = WACK;
                        end
                    end
                end
            end
            READ: begin
                if (d_fire) begin
                    if (!burst_q || beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        rd_en  = 1'b1;
                        rd_idx = {base_q, beat_q + 2'd1};
                    end
                end
            end
            WRITE: begin
                if (a_fire) begin
                    wr_en  = 1'b1;
                    wr_idx = {base_q, beat_q};
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = WACK;
                    end
                end
            end
            WACK: begin
                if (d_fire) begin
                    beat_d  = 2'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            base_q   <= '0;
            source_q <= 1'b0;
            size_q   <= 4'd0;
            denied_q <= 1'b0;
            burst_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            base_q   <= base_d;
            source_q <= source_d;
            size_q   <= size_d;
            denied_q <= denied_d;
            burst_q  <= burst_d;
        end
    end

    // RAM keeps its contents across reset; the read register only loads on an issued read,
    // which keeps D data steady under backpressure.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (io_a_bits_mask[b]) begin
                    mem[wr_idx][8*b +: 8] <= io_a_bits_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end
endmodule

// File: tb/tb_tl_ram_responder.sv
// Directed self-checking bench for tl_ram_responder: inputs are driven and outputs
// sampled on the falling clock edge.
module tb_tl_ram_responder;
    logic        clock;
    logic        reset;
    logic        io_a_ready;
    logic        io_a_valid;
    logic [2:0]  io_a_bits_opcode;
    logic [3:0]  io_a_bits_size;
    logic        io_a_bits_source;
    logic [31:0] io_a_bits_address;
    logic [3:0]  io_a_bits_mask;
    logic [31:0] io_a_bits_data;
    logic        io_d_ready;
    logic        io_d_valid;
    logic [2:0]  io_d_bits_opcode;
    logic [3:0]  io_d_bits_size;
    logic        io_d_bits_source;
    logic        io_d_bits_denied;
    logic [31:0] io_d_bits_data;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    tl_ram_responder #(.DEPTH_WORDS(1024)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_a_ready        (io_a_ready),
        .io_a_valid        (io_a_valid),
        .io_a_bits_opcode  (io_a_bits_opcode),
        .io_a_bits_size    (io_a_bits_size),
        .io_a_bits_source  (io_a_bits_source),
        .io_a_bits_address (io_a_bits_address),
        .io_a_bits_mask    (io_a_bits_mask),
        .io_a_bits_data    (io_a_bits_data),
        .io_d_ready        (io_d_ready),
        .io_d_valid        (io_d_valid),
        .io_d_bits_opcode  (io_d_bits_opcode),
        .io_d_bits_size    (io_d_bits_size),
        .io_d_bits_source  (io_d_bits_source),
        .io_d_bits_denied  (io_d_bits_denied),
        .io_d_bits_data    (io_d_bits_data),
        .dbg_state         (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Offer one A beat from a falling edge and return at the falling edge after it fires.
    task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int n;
        n = 0;
        io_a_valid        = 1'b1;
        io_a_bits_opcode  = op;
        io_a_bits_size    = sz;
        io_a_bits_source  = src;
        io_a_bits_address = addr;
        io_a_bits_mask    = mask;
        io_a_bits_data    = data;
        while (!io_a_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("a_accept", io_a_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        io_a_valid = 1'b0;
    endtask

    // The D beat must be present now; with io_d_ready high it is taken at the next edge.
    task automatic expect_d(input string tag, input logic [2:0] op, input logic [3:0] sz,
                            input logic src, input logic den, input logic [31:0] data);
        check_eq({tag, "_valid"},  io_d_valid, 1'b1);
        check_eq({tag, "_opcode"}, io_d_bits_opcode, op);
        check_eq({tag, "_size"},   io_d_bits_size, sz);
        check_eq({tag, "_source"}, io_d_bits_source, src);
        check_eq({tag, "_denied"}, io_d_bits_denied, den);
        check_eq({tag, "_data"},   io_d_bits_data, data);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int got;
        int cyc;
        reset             = 1'b1;
        io_a_valid        = 1'b0;
        io_a_bits_opcode  = 3'd0;
        io_a_bits_size    = 4'd0;
        io_a_bits_source  = 1'b0;
        io_a_bits_address = 32'd0;
        io_a_bits_mask    = 4'd0;
        io_a_bits_data    = 32'd0;
        io_d_ready        = 1'b1;

        @(posedge clock);
        @(negedge clock);
        check_eq("rst_a_ready", io_a_ready, 1'b0);
        check_eq("rst_d_valid", io_d_valid, 1'b0);
        check_eq("rst_d_opcode", io_d_bits_opcode, 3'd0);
        check_eq("rst_d_data", io_d_bits_data, 32'd0);
        check_eq("rst_state", dbg_state, 2'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("post_rst_a_ready", io_a_ready, 1'b1);
        @(negedge clock);

        // Single Put then Get
        send_a(3'd0, 4'd2, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        expect_d("put1", 3'd0, 4'd2, 1'b1, 1'b0, 32'd0);
        send_a(3'd4, 4'd2, 1'b0, 32'h100, 4'h0, 32'd0);
        expect_d("get1", 3'd1, 4'd2, 1'b0, 1'b0, 32'hDEADBEEF);

        // Partial write
        send_a(3'd0, 4'd2, 1'b0, 32'h104, 4'hF, 32'h11223344);
        expect_d("put2", 3'd0, 4'd2, 1'b0, 1'b0, 32'd0);
        send_a(3'd1, 4'd2, 1'b1, 32'h104, 4'h5, 32'hAABBCCDD);
        expect_d("pput", 3'd0, 4'd2, 1'b1, 1'b0, 32'd0);
        send_a(3'd4, 4'd2, 1'b1, 32'h104, 4'h0, 32'd0);
        expect_d("get2", 3'd1, 4'd2, 1'b1, 1'b0, 32'h11BB33DD);

        // Burst Put 1..4 at 0x200 with a one-cycle gap after beat 1
        for (int i = 0; i < 4; i++) begin
            send_a(3'd0, 4'd4, 1'b1, 32'h200 + 32'(i * 4), 4'hF, 32'(i + 1));
            if (i < 3) check_eq("bput_noack", io_d_valid, 1'b0);
            if (i == 1) @(negedge clock);
        end
        expect_d("bput", 3'd0, 4'd4, 1'b1, 1'b0, 32'd0);
        check_eq("bput_single_ack", io_d_valid, 1'b0);

        // Burst Get at 0x208: low bits ignored, beats back-to-back, IDLE at t+5
        send_a(3'd4, 4'd4, 1'b0, 32'h208, 4'h0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_d("bget", 3'd1, 4'd4, 1'b0, 1'b0, 32'(i + 1));
        end
        check_eq("bget_done_a_ready", io_a_ready, 1'b1);
        check_eq("bget_done_d_valid", io_d_valid, 1'b0);

        // Address aliases modulo the 4 KiB RAM
        send_a(3'd4, 4'd2, 1'b1, 32'h1100, 4'h0, 32'd0);
        expect_d("alias", 3'd1, 4'd2, 1'b1, 1'b0, 32'hDEADBEEF);

        // Backpressure on a burst Get
        io_d_ready = 1'b0;
        send_a(3'd4, 4'd4, 1'b1, 32'h200, 4'h0, 32'd0);
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 40) begin
            check_eq("bp_valid", io_d_valid, 1'b1);
            check_eq("bp_a_ready", io_a_ready, 1'b0);
            check_eq("bp_data", io_d_bits_data, 32'(got + 1));
            io_d_ready = (cyc % 2 == 1);
            @(posedge clock);
            if (io_d_ready) got++;
            @(negedge clock);
            cyc++;
        end
        check_eq("bp_beats", got, 4);
        check_eq("bp_end_valid", io_d_valid, 1'b0);
        io_d_ready = 1'b1;

        // Illegal Get (size 3)
        send_a(3'd4, 4'd3, 1'b0, 32'h100, 4'h0, 32'd0);
        expect_d("ill_get", 3'd1, 4'd3, 1'b0, 1'b1, 32'd0);
        check_eq("ill_get_single", io_d_valid, 1'b0);

        // Illegal opcode 2 and illegal Put size 5 leave the RAM untouched
        send_a(3'd2, 4'd2, 1'b1, 32'h100, 4'hF, 32'h12345678);
        expect_d("ill_op", 3'd0, 4'd2, 1'b1, 1'b1, 32'd0);
        send_a(3'd0, 4'd5, 1'b0, 32'h104, 4'hF, 32'hFFFFFFFF);
        expect_d("ill_size", 3'd0, 4'd5, 1'b0, 1'b1, 32'd0);
        send_a(3'd4, 4'd2, 1'b0, 32'h100, 4'h0, 32'd0);
        expect_d("ill_keep0", 3'd1, 4'd2, 1'b0, 1'b0, 32'hDEADBEEF);
        send_a(3'd4, 4'd2, 1'b0, 32'h104, 4'h0, 32'd0);
        expect_d("ill_keep1", 3'd1, 4'd2, 1'b0, 1'b0, 32'h11BB33DD);

        // Reset after beat 0 of a burst Get has been taken
        send_a(3'd4, 4'd4, 1'b0, 32'h200, 4'h0, 32'd0);
        expect_d("rb_beat0", 3'd1, 4'd4, 1'b0, 1'b0, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_eq("rb_d_valid", io_d_valid, 1'b0);
        check_eq("rb_a_ready_in_reset", io_a_ready, 1'b0);
        reset = 1'b0;
        #1;
        check_eq("rb_a_ready_after", io_a_ready, 1'b1);
        @(negedge clock);
        send_a(3'd4, 4'd2, 1'b1, 32'h20C, 4'h0, 32'd0);
        expect_d("rb_keep_burst", 3'd1, 4'd2, 1'b1, 1'b0, 32'd4);
        send_a(3'd4, 4'd2, 1'b0, 32'h100, 4'h0, 32'd0);
        expect_d("rb_keep_single", 3'd1, 4'd2, 1'b0, 1'b0, 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
